vga_sync_receiver: RTL and testbench

Receive-side counterpart to the VGA sync/porch generator. Samples an incoming 640x480 VGA stream (active-low HSync/VSync plus 3-bit RGB, pixel-clock synchronous to i_Clk) and recovers pixel coordinates from the sync edges. Verifies line and frame lengths against the expected 800x525 timing, and emits only coordinate-tagged active pixels once lock is established. Sits between the VGA pins (or a loopback from the generator) and any frame-capture or pattern-checker logic.

---
 rtl/vga_sync_receiver.sv | 169 ++++++++++++++++
 tb/tb_vga_sync_receiver.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_receiver.sv
// VGA receive-side timing recovery: rebuilds pixel coordinates from the sync edges,
// checks line/frame lengths and forwards coordinate-tagged active pixels once locked.
//
// state      | meaning
// UNLOCKED   | idle, waiting for a VSync fall to begin checking
// CHECKING   | measuring frames, counting consecutive good ones
// LOCKED     | timing verified, active pixels forwarded
module vga_sync_receiver #(
  parameter int c_VIDEO_WIDTH    = 3,
  parameter int c_TOTAL_COLS     = 800,
  parameter int c_TOTAL_ROWS     = 525,
  parameter int c_ACTIVE_COLS    = 640,
  parameter int c_ACTIVE_ROWS    = 480,
  parameter int c_H_ACTIVE_START = 144,
  parameter int c_V_ACTIVE_START = 35,
  parameter int c_LOCK_FRAMES    = 2
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset,
  input  logic                     i_HSync,
  input  logic                     i_VSync,
  input  logic [c_VIDEO_WIDTH-1:0] i_Red_Video,
  input  logic [c_VIDEO_WIDTH-1:0] i_Grn_Video,
  input  logic [c_VIDEO_WIDTH-1:0] i_Blu_Video,
  output logic                     o_Locked,
  output logic                     o_Active,
  output logic [9:0]               o_Col,
  output logic [9:0]               o_Row,
  output logic [c_VIDEO_WIDTH-1:0] o_Red_Video,
  output logic [c_VIDEO_WIDTH-1:0] o_Grn_Video,
  output logic [c_VIDEO_WIDTH-1:0] o_Blu_Video,
  output logic                     o_Frame_Start
);
  localparam int VW = 3 * c_VIDEO_WIDTH;
  localparam int GW = $clog2(c_LOCK_FRAMES + 1);

  localparam logic [1:0] S_UNLOCKED = 2'd0;
  localparam logic [1:0] S_CHECKING = 2'd1;
  localparam logic [1:0] S_LOCKED   = 2'd2;

  localparam logic [9:0]    CNT_MAX   = 10'h3FF;
  localparam logic [10:0]   LINE_LEN  = 11'(c_TOTAL_COLS);
  localparam logic [9:0]    FRAME_LEN = 10'(c_TOTAL_ROWS);
  localparam logic [9:0]    H_LO      = 10'(c_H_ACTIVE_START);
  localparam logic [10:0]   H_HI      = 11'(c_H_ACTIVE_START + c_ACTIVE_COLS);
  localparam logic [9:0]    V_LO      = 10'(c_V_ACTIVE_START);
  localparam logic [10:0]   V_HI      = 11'(c_V_ACTIVE_START + c_ACTIVE_ROWS);
  localparam logic [GW-1:0] GOOD_LAST = GW'(c_LOCK_FRAMES - 1);

  logic          hs_r1_q, hs_r2_q, vs_r1_q, vs_r2_q;
  logic [VW-1:0] vid_r1_q, vid_r2_q;
  logic [9:0]    h_cnt_q, h_cnt_d;
  logic [9:0]    line_cnt_q, line_cnt_d;
  logic [1:0]    state_q, state_d;
  logic [GW-1:0] good_cnt_q, good_cnt_d;
  logic          hs_seen_q, hs_seen_d;
  logic          frame_bad_q, frame_bad_d;

  logic hs_fall, vs_fall, line_bad, frame_bad;
  logic h_in, v_in, active;

  assign hs_fall = hs_r2_q & ~hs_r1_q;
  assign vs_fall = vs_r2_q & ~vs_r1_q;

  always_comb begin
    h_cnt_d = h_cnt_q;
    if (hs_fall) begin
      h_cnt_d = '0;
    end else if (h_cnt_q != CNT_MAX) begin
      h_cnt_d = h_cnt_q + 10'd1;
    end
  end

  // VSync wins over a coincident HSync fall
  always_comb begin
    line_cnt_d = line_cnt_q;
    if (vs_fall) begin
      line_cnt_d = '0;
    end else if (hs_fall && (line_cnt_q != CNT_MAX)) begin
      line_cnt_d = line_cnt_q + 10'd1;
    end
  end

  // a saturated h_cnt means HSync has gone missing: treat as a bad line
  assign line_bad  = (hs_fall & hs_seen_q & (({1'b0, h_cnt_q} + 11'd1) != LINE_LEN))
                   | (h_cnt_q == CNT_MAX);
  assign frame_bad = vs_fall & ((line_cnt_q != FRAME_LEN) | frame_bad_q | line_bad);

  always_comb begin
    state_d     = state_q;
    good_cnt_d  = good_cnt_q;
    hs_seen_d   = hs_seen_q | hs_fall;
    frame_bad_d = frame_bad_q;
    case (state_q)
      S_UNLOCKED: begin
        hs_seen_d   = 1'b0;
        frame_bad_d = 1'b0;
        good_cnt_d  = '0;
        if (vs_fall) begin
          state_d = S_CHECKING;
        end
      end
      S_CHECKING: begin
        if (vs_fall) begin
          frame_bad_d = 1'b0;
          if (frame_bad) begin
            good_cnt_d = '0;
          end else if (good_cnt_q == GOOD_LAST) begin
            state_d = S_LOCKED;
          end else begin
            good_cnt_d = good_cnt_q + GW'(1);
          end
        end else if (line_bad) begin
          frame_bad_d = 1'b1;
        end
      end
      S_LOCKED: begin
        frame_bad_d = 1'b0;
        if (line_bad || frame_bad) begin
          state_d = S_UNLOCKED;
        end
      end
      default: state_d = S_UNLOCKED;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      hs_r1_q     <= 1'b1;
      hs_r2_q     <= 1'b1;
      vs_r1_q     <= 1'b1;
      vs_r2_q     <= 1'b1;
      vid_r1_q    <= '0;
      vid_r2_q    <= '0;
      h_cnt_q     <= '0;
      line_cnt_q  <= '0;
      state_q     <= S_UNLOCKED;
      good_cnt_q  <= '0;
      hs_seen_q   <= 1'b0;
      frame_bad_q <= 1'b0;
    end else begin
      hs_r1_q     <= i_HSync;
      hs_r2_q     <= hs_r1_q;
      vs_r1_q     <= i_VSync;
      vs_r2_q     <= vs_r1_q;
      vid_r1_q    <= {i_Red_Video, i_Grn_Video, i_Blu_Video};
      vid_r2_q    <= vid_r1_q;
      h_cnt_q     <= h_cnt_d;
      line_cnt_q  <= line_cnt_d;
      state_q     <= state_d;
      good_cnt_q  <= good_cnt_d;
      hs_seen_q   <= hs_seen_d;
      frame_bad_q <= frame_bad_d;
    end
  end

  // counters run one stage behind r1, so they line up with the pixel in r2
  assign h_in   = (h_cnt_q >= H_LO) && ({1'b0, h_cnt_q} < H_HI);
  assign v_in   = (line_cnt_q >= V_LO) && ({1'b0, line_cnt_q} < V_HI);
  assign active = (state_q == S_LOCKED) && h_in && v_in;

  assign o_Locked      = (state_q == S_LOCKED);
  assign o_Active      = active;
  assign o_Col         = active ? (h_cnt_q - H_LO) : '0;
  assign o_Row         = active ? (line_cnt_q - V_LO) : '0;
  assign {o_Red_Video, o_Grn_Video, o_Blu_Video} = active ? vid_r2_q : '0;
  assign o_Frame_Start = active && (h_cnt_q == H_LO) && (line_cnt_q == V_LO);

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver on a scaled-down 40x12 raster: the driver queues expected
// pixels and lock transitions; a monitor pops and compares them as the DUT presents them.
module tb_vga_sync_receiver;
  localparam int COLS  = 40;
  localparam int ROWS  = 12;
  localparam int ACOLS = 16;
  localparam int AROWS = 6;
  localparam int HST   = 10;
  localparam int VST   = 3;
  localparam int HSW   = 4;
  localparam int LOCKN = 2;
  localparam int LONG_HIGH = 1100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, hs, vs;
  logic [2:0] ri, gi, bi;
  logic       locked, active, fstart;
  logic [9:0] col, row;
  logic [2:0] ro, go, bo;

  vga_sync_receiver #(
    .c_VIDEO_WIDTH(3), .c_TOTAL_COLS(COLS), .c_TOTAL_ROWS(ROWS),
    .c_ACTIVE_COLS(ACOLS), .c_ACTIVE_ROWS(AROWS),
    .c_H_ACTIVE_START(HST), .c_V_ACTIVE_START(VST), .c_LOCK_FRAMES(LOCKN)
  ) dut (
    .i_Clk(clk), .i_Reset(rst), .i_HSync(hs), .i_VSync(vs),
    .i_Red_Video(ri), .i_Grn_Video(gi), .i_Blu_Video(bi),
    .o_Locked(locked), .o_Active(active), .o_Col(col), .o_Row(row),
    .o_Red_Video(ro), .o_Grn_Video(go), .o_Blu_Video(bo),
    .o_Frame_Start(fstart)
  );

  typedef struct {
    int         cyc;
    int         c;
    int         r;
    logic [2:0] red;
    logic [2:0] grn;
    logic [2:0] blu;
    bit         fs;
  } px_t;

  typedef struct {
    int cyc;
    bit val;
  } lk_t;

  px_t px_q[$];
  lk_t lk_q[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit chk_zero = 1'b0;
  bit mon_en   = 1'b0;
  bit done     = 1'b0;
  int n_tests  = 0;
  int n_fail   = 0;

  // Pins driven in period p show up on the outputs in period p+2.
  // VSync falls one clock after the HSync fall of line 0 and rises one clock after line 2's.
  task automatic send_frame(input int nrows, input int short_row, input int long_row,
                            input int rst_row, input bit exp_act, input int vs_evt);
    for (int ln = 0; ln < nrows; ln++) begin
      int len;
      len = COLS;
      if (ln == short_row) len = COLS - 1;
      if (ln == long_row) len = HSW + LONG_HIGH;
      for (int h = 0; h < len; h++) begin
        bit act;
        int c;
        int r;
        @(posedge clk);
        #1;
        hs  = (h < HSW) ? 1'b0 : 1'b1;
        vs  = ((ln == 0 && h >= 1) || ln == 1 || (ln == 2 && h == 0)) ? 1'b0 : 1'b1;
        rst = (ln == rst_row && h == 0);
        c   = h - HST;
        r   = ln - VST;
        act = (c >= 0) && (c < ACOLS) && (r >= 0) && (r < AROWS);
        if (act) begin
          ri = c[2:0];
          gi = r[2:0];
          bi = c[2:0] ^ r[2:0];
        end else begin
          ri = 3'($urandom);
          gi = 3'($urandom);
          bi = 3'($urandom);
        end
        if (exp_act && act && (rst_row < 0 || ln < rst_row)) begin
          px_t e;
          e.cyc = cyc + 2; e.c = c; e.r = r;
          e.red = ri; e.grn = gi; e.blu = bi;
          e.fs  = (c == 0 && r == 0);
          px_q.push_back(e);
        end
        if (ln == 0 && h == 1 && vs_evt >= 0) begin
          lk_t l;
          l.cyc = cyc + 2; l.val = (vs_evt == 1);
          lk_q.push_back(l);
        end
        if (short_row >= 0 && ln == short_row + 1 && h == 0) begin
          lk_t l;
          l.cyc = cyc + 2; l.val = 1'b0;
          lk_q.push_back(l);
        end
        if (ln == long_row && h == 0) begin
          lk_t l;
          l.cyc = cyc + 1026; l.val = 1'b0;
          lk_q.push_back(l);
        end
        if (ln == rst_row && h == 0) begin
          lk_t l;
          l.cyc = cyc + 1; l.val = 1'b0;
          lk_q.push_back(l);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; hs = 1'b1; vs = 1'b1;
    ri = 3'($urandom); gi = 3'($urandom); bi = 3'($urandom);
    repeat (5) begin
      @(posedge clk);
      #1;
      hs = 1'($urandom); vs = 1'($urandom);
      ri = 3'($urandom); gi = 3'($urandom); bi = 3'($urandom);
      chk_zero = 1'b1;
    end
    @(posedge clk);
    #1;
    rst = 1'b0; hs = 1'b1; vs = 1'b1; chk_zero = 1'b0; mon_en = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    //          rows  short long rst exp vs_evt
    send_frame(ROWS,   -1,   -1,  -1, 0, -1);   // enter CHECKING
    send_frame(ROWS,   -1,   -1,  -1, 0, -1);   // good frame 1
    send_frame(ROWS,   -1,   -1,  -1, 1,  1);   // lock rises
    send_frame(ROWS,   10,   -1,  -1, 1, -1);   // 39-clock line drops lock
    send_frame(ROWS,   -1,   -1,  -1, 0, -1);
    send_frame(ROWS,   -1,   -1,  -1, 0, -1);
    send_frame(ROWS,   -1,   10,  -1, 1,  1);   // relock, then HSync timeout
    send_frame(ROWS,   -1,   -1,  -1, 0, -1);
    send_frame(ROWS,   -1,   -1,  -1, 0, -1);
    send_frame(ROWS+1, -1,   -1,  -1, 1,  1);   // relock, frame one line too long
    send_frame(ROWS,   -1,   -1,  -1, 0,  0);   // unlock on its VSync fall
    send_frame(ROWS,   -1,   -1,  -1, 0, -1);
    send_frame(ROWS,   -1,   -1,  -1, 0, -1);
    send_frame(ROWS,   -1,   -1,   5, 1,  1);   // relock, reset mid-frame
    send_frame(ROWS,   -1,   -1,  -1, 0, -1);
    send_frame(ROWS,   -1,   -1,  -1, 0, -1);
    send_frame(ROWS,   -1,   -1,  -1, 1,  1);   // final relock, full frame out
    send_frame(3,      -1,   -1,  -1, 0, -1);
    repeat (4) @(posedge clk);
    done = 1'b1;
  end

  initial begin
    bit prev_locked;
    prev_locked = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_zero) begin
        n_tests++;
        if ({locked, active, fstart, col, row, ro, go, bo} !== '0) begin
          n_fail++;
          $display("FAIL reset_outputs: got locked=%b active=%b fs=%b col=%0d row=%0d rgb=%0d/%0d/%0d, required all 0",
                   locked, active, fstart, col, row, ro, go, bo);
        end
      end
      if (mon_en) begin
        if (locked !== prev_locked) begin
          n_tests++;
          if (lk_q.size() == 0) begin
            n_fail++;
            $display("FAIL lock_change: got o_Locked=%b at cycle %0d, required no change", locked, cyc);
          end else begin
            lk_t l;
            l = lk_q.pop_front();
            if (l.cyc != cyc || l.val !== locked) begin
              n_fail++;
              $display("FAIL lock_change: got o_Locked=%b at cycle %0d, required %b at cycle %0d",
                       locked, cyc, l.val, l.cyc);
            end
          end
          prev_locked = locked;
        end
        n_tests++;
        if (active === 1'b1) begin
          if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL active_unlocked: got o_Active=1 o_Locked=%b at cycle %0d, required o_Locked=1", locked, cyc);
          end else if (px_q.size() == 0) begin
            n_fail++;
            $display("FAIL pixel_extra: got col=%0d row=%0d at cycle %0d, required no active pixel", col, row, cyc);
          end else begin
            px_t e;
            e = px_q.pop_front();
            if (e.cyc != cyc || int'(col) != e.c || int'(row) != e.r || ro !== e.red ||
                go !== e.grn || bo !== e.blu || fstart !== e.fs) begin
              n_fail++;
              $display("FAIL pixel: got cyc=%0d col=%0d row=%0d rgb=%0d/%0d/%0d fs=%b, required cyc=%0d col=%0d row=%0d rgb=%0d/%0d/%0d fs=%b",
                       cyc, col, row, ro, go, bo, fstart, e.cyc, e.c, e.r, e.red, e.grn, e.blu, e.fs);
            end
          end
        end else if ({fstart, ro, go, bo} !== '0 || active !== 1'b0) begin
          n_fail++;
          $display("FAIL idle_outputs: got active=%b fs=%b rgb=%0d/%0d/%0d at cycle %0d, required 0",
                   active, fstart, ro, go, bo, cyc);
        end
      end
      if (done) begin
        n_tests++;
        if (px_q.size() != 0) begin
          n_fail++;
          $display("FAIL pixels_missing: got %0d pixels left unseen, required 0", px_q.size());
        end
        n_tests++;
        if (lk_q.size() != 0) begin
          n_fail++;
          $display("FAIL lock_missing: got %0d lock changes left unseen, required 0", lk_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end
    end
  end

endmodule
